// File: rtl/daq_wb_master.sv
// Wishbone B3 classic single-access master behind the DAQ file state machine.
// One bus cycle per start/active request, with bus timeout, bounded rty retry and sticky error.
module daq_wb_master #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 256,
    parameter int RETRIES = 3
) (
    input  logic          wb_clk,
    input  logic          wb_rst,

    input  logic          start,
    input  logic [aw-1:0] address,
    input  logic [3:0]    selection,
    input  logic          write,
    input  logic [dw-1:0] data_wr,
    output logic [dw-1:0] data_rd,
    output logic          active,
    output logic          bus_error,
    input  logic          error_clear,

    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUS   = 2'd1;
    localparam logic [1:0] ST_RETRY = 2'd2;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RTY_MAX  = 4'(RETRIES);

    logic [1:0]    state_q, state_d;
    logic          armed_q, armed_d;
    logic [15:0]   tmo_q, tmo_d;
    logic [3:0]    rty_q, rty_d;
    logic [aw-1:0] adr_q, adr_d;
    logic [dw-1:0] dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          active_q, active_d;
    logic [dw-1:0] rd_q, rd_d;
    logic          err_q, err_d;
    logic          fail;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        rty_d    = rty_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        active_d = active_q;
        rd_d     = rd_q;
        fail     = 1'b0;
        // A level-held start may only launch one access; it must be seen low to re-arm.
        armed_d  = armed_q | ~start;
        err_d    = error_clear ? 1'b0 : err_q;

        case (state_q)
            ST_IDLE: begin
                if (start && armed_q) begin
                    adr_d    = address;
                    sel_d    = selection;
                    we_d     = write;
                    dat_d    = write ? data_wr : '0;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    active_d = 1'b1;
                    tmo_d    = '0;
                    rty_d    = '0;
                    armed_d  = 1'b0;
                    state_d  = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_ack_i) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (!we_q) begin
                        rd_d = wb_dat_i;
                    end
                end else if (wb_err_i) begin
                    fail = 1'b1;
                end else if (wb_rty_i) begin
                    if (rty_q < RTY_MAX) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        rty_d   = rty_q + 4'd1;
                        tmo_d   = '0;
                        state_d = ST_RETRY;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_RETRY: begin
                // Single idle cycle between attempts; request fields stay latched.
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                tmo_d   = '0;
                state_d = ST_BUS;
            end
            default: begin
                cyc_d    = 1'b0;
                stb_d    = 1'b0;
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        if (fail) begin
            cyc_d    = 1'b0;
            stb_d    = 1'b0;
            active_d = 1'b0;
            rd_d     = '0;
            err_d    = 1'b1;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q  <= ST_IDLE;
            armed_q  <= 1'b1;
            tmo_q    <= '0;
            rty_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            active_q <= 1'b0;
            rd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            tmo_q    <= tmo_d;
            rty_q    <= rty_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            active_q <= active_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_cti_o  = 3'b000;
    assign wb_bte_o  = 2'b00;
    assign data_rd   = rd_q;
    assign active    = active_q;
    assign bus_error = err_q;

endmodule

// File: doc/daq_wb_master.md
Name: daq_wb_master

Overview:
- Wishbone classic single-access bus master directly downstream of the DAQ file state machine.
- Converts that block's level start/active memory-request handshake into one Wishbone B3 classic cycle per request. Returns read data, and drops active when the access completes.
- Adds a bus timeout, bounded retry on wb_rty_i, and a sticky error report so a hung slave cannot deadlock the DAQ path.

Parameters:
dw, 32, data width of request and Wishbone data buses
aw, 32, address width
TIMEOUT, 256, cycles to wait for ack/err/rty before abandoning an access (1..65535)
RETRIES, 3, maximum re-issues of an access terminated by wb_rty_i (0..15)

Ports:
wb_clk  in  1  clock
wb_rst  in  1  synchronous active-high reset
start  in  1  request level from DAQ SM; held high until active seen
address  in  aw  request byte address
selection  in  4  request byte lane enables
write  in  1  1=write, 0=read
data_wr  in  dw  write data
data_rd  out  dw  read data; valid when active falls after a read
active  out  1  access in progress
bus_error  out  1  sticky: an access ended in err, timeout or retry exhaustion
error_clear  in  1  single-cycle pulse; clears bus_error
wb_adr_o  out  aw  Wishbone address
wb_dat_o  out  dw  Wishbone write data
wb_sel_o  out  4  Wishbone select
wb_we_o  out  1  Wishbone write enable
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_cti_o  out  3  fixed 3'b000 (classic)
wb_bte_o  out  2  fixed 2'b00
wb_dat_i  in  dw  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
wb_rty_i  in  1  Wishbone retry

Behaviour:
- Reset: all outputs 0. State IDLE, armed=1, timeout counter=0, retry counter=0. Reset mid-cycle drops cyc/stb on the next edge, with no completion reported.
- armed flag: cleared when a request is accepted; set in any cycle where start==0. Prevents a still-high start from re-triggering after completion.
- IDLE: if start && armed, latch address/selection/write/data_wr into wb_*_o. Next cycle: cyc=stb=1, active=1. State BUS, timeout counter=0, retry counter=0.
- Latency: start sampled at edge 0 -> cyc/stb/active high after edge 0. A zero-wait slave acking in that cycle gives cyc/stb/active low after edge 1, i.e. a 2-cycle minimum.
- BUS: priority when several terminations are asserted together is ack > err > rty.
- BUS, ack: cyc=stb=0, active=0, state IDLE.
  - Read: data_rd <= wb_dat_i on the same edge.
  - Write: data_rd unchanged.
- BUS, err: terminate as for ack, data_rd <= 0, bus_error <= 1.
- BUS, rty:
  - If retry counter < RETRIES: cyc=stb=0 for exactly one cycle (state RETRY), then re-issue the identical access. Retry counter +1, timeout counter=0, active stays 1.
  - Else: terminate as for err.
- BUS timeout: the counter increments each BUS cycle without a termination. On reaching TIMEOUT-1 with no termination, terminate as for err.
- active stays 1 continuously through BUS and RETRY; it never glitches low mid-access.
- Address, data, select and we are held stable throughout BUS and RETRY.
- Inputs start/address/data are ignored while active.
- error_clear: clears bus_error. If error_clear and a new error occur on the same edge, the set wins.
- wb_dat_o is driven only for writes; for reads it is 0.

Test Plan:
- Read, slave acks 1 cycle after stb with wb_dat_i=32'h1234_5678, address=32'h0000_0020 -> wb_adr_o=32'h20, we=0, sel=4'hF; active high 2 cycles; data_rd=32'h12345678 when active falls; bus_error=0.
- Write, address=32'h100, data_wr=32'hAABBCCDD, sel=4'h4, ack after 3 wait states -> wb_we_o=1, wb_dat_o=32'hAABBCCDD, wb_sel_o=4'h4 stable 4 cycles; exactly one cycle issued.
- start held high 3 cycles after active falls, then low, then high again -> exactly two Wishbone cycles total; second begins only after start was seen low.
- Slave asserts rty on the first two attempts, ack on the third (RETRIES=3) -> three stb assertions, each separated by one idle cycle; active continuously high; bus_error=0.
- Slave never responds (TIMEOUT=256) -> cyc drops after 256 cycles, data_rd=0, bus_error=1. Then error_clear pulse -> bus_error=0.
- Assert wb_rst two cycles into a waited access -> cyc/stb/active=0 the next cycle, data_rd=0, bus_error=0; a following request completes normally.
